// File: rtl/fpu_status_collector.sv
// FPU status collector: sticky IEEE flags, maskable irq and a per-operation flag record FIFO.
// Optional FPU_STAT_TRAP_EN adds a single-cycle trap pulse per unmasked event.
module fpu_status_collector #(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ready,
  input  logic                     ine,
  input  logic                     overflow,
  input  logic                     underflow,
  input  logic                     div_zero,
  input  logic                     inf,
  input  logic                     zero,
  input  logic                     qnan,
  input  logic                     snan,
  input  logic                     clr,
  input  logic [4:0]               irq_mask,
  output logic [4:0]               fflags,
  output logic                     irq,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [7:0]               rec_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic [CNT_W-1:0]         op_cnt
`ifdef FPU_STAT_TRAP_EN
  ,
  output logic                     trap
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]    new5;
  logic [4:0]    fflags_next;
  logic [7:0]    rec;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  always_comb begin
    new5        = {snan, div_zero, overflow, underflow, ine};
    rec         = {snan, qnan, zero, inf, div_zero, underflow, overflow, ine};
    // A new event survives a same-cycle clear.
    fflags_next = (clr ? 5'b0 : fflags) | (ready ? new5 : 5'b0);
    rec_valid   = (fifo_count != '0);
    full        = (fifo_count == FULL_CNT);
    pop         = rec_valid & rec_ready;
    // When full, a same-cycle pop frees the slot the push will take.
    push        = ready & (~full | pop);
    drop        = ready & full & ~pop;
    rec_data    = rec_valid ? mem[rd_ptr] : 8'h00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fflags <= '0;
      irq    <= 1'b0;
      op_cnt <= '0;
    end else begin
      fflags <= fflags_next;
      irq    <= |(fflags_next & irq_mask);
      if (ready) op_cnt <= op_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (clr) begin
      drop_cnt <= drop ? DROP_W'(1) : '0;
    end else if (drop && !(&drop_cnt)) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  // Storage is not reset; occupancy gates what is visible on rec_data.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef FPU_STAT_TRAP_EN
  // Fires on every unmasked event, independent of the sticky state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) trap <= 1'b0;
    else      trap <= ready & (|(new5 & irq_mask));
  end
`endif

endmodule

// File: tb/tb_fpu_status_collector.sv
// Scoreboard bench for fpu_status_collector: stimulus queues expected records,
// a negedge monitor checks every handshake; register outputs checked directly.
module tb_fpu_status_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready, ine, overflow, underflow, div_zero, inf, zero, qnan, snan, clr;
  logic [4:0]  irq_mask;
  logic [4:0]  fflags;
  logic        irq, rec_valid, rec_ready;
  logic [7:0]  rec_data;
  logic [3:0]  fifo_count;
  logic [7:0]  drop_cnt;
  logic [15:0] op_cnt;
`ifdef FPU_STAT_TRAP_EN
  logic        trap;
`endif

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] exp_q [$];

  fpu_status_collector #(.DEPTH(8), .CNT_W(16), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .ready(ready), .ine(ine), .overflow(overflow),
    .underflow(underflow), .div_zero(div_zero), .inf(inf), .zero(zero),
    .qnan(qnan), .snan(snan), .clr(clr), .irq_mask(irq_mask),
    .fflags(fflags), .irq(irq), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_data(rec_data), .fifo_count(fifo_count), .drop_cnt(drop_cnt),
    .op_cnt(op_cnt)
`ifdef FPU_STAT_TRAP_EN
    , .trap(trap)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [7:0] r);
    {snan, qnan, zero, inf, div_zero, underflow, overflow, ine} = r;
  endtask

  task automatic op(input logic [7:0] r);
    set_flags(r);
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    set_flags(8'h00);
  endtask

  task automatic drain();
    rec_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0 && fifo_count == 4'd0) break;
      cyc();
    end
    rec_ready = 1'b0;
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_fifo_count", fifo_count, 0);
  endtask

  // Monitor: every accepted record must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rec_unexpected: got %0h expected none at %0t", rec_data, $time);
      end else begin
        chk("rec_data", rec_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ready = 1'b0; clr = 1'b0; irq_mask = 5'b0; rec_ready = 1'b0;
    set_flags(8'h00);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();

    // Async reset mid-cycle while an op is in flight.
    ready = 1'b1; overflow = 1'b1;
    cyc();
    chk("pre_reset_fifo_count", fifo_count, 1);
    #3 rst = 1'b0;
    #1;
    chk("rst_fflags", fflags, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rec_valid", rec_valid, 0);
    chk("rst_rec_data", rec_data, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_op_cnt", op_cnt, 0);
    ready = 1'b0; overflow = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    chk("post_rst_fifo_count", fifo_count, 0);
    chk("post_rst_fflags", fflags, 0);

    // Single op: ine + zero.
    exp_q.push_back(8'h21);
    op(8'h21);
    chk("single_fflags", fflags, 5'b00001);
    chk("single_rec_valid", rec_valid, 1);
    chk("single_rec_data", rec_data, 8'h21);
    chk("single_op_cnt", op_cnt, 1);
    rec_ready = 1'b1;
    cyc();
    rec_ready = 1'b0;
    chk("single_pop_count", fifo_count, 0);

    // Empty-FIFO rec_ready has no effect.
    rec_ready = 1'b1;
    cyc();
    rec_ready = 1'b0;
    chk("empty_pop_count", fifo_count, 0);

    clr = 1'b1; cyc(); clr = 1'b0;

    // Ten ops into an 8-deep FIFO with no consumer.
    begin
      logic [7:0] recs [10];
      recs = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h03, 8'h05};
      for (int i = 0; i < 10; i++) begin
        if (i < 8) exp_q.push_back(recs[i]);
        op(recs[i]);
      end
    end
    chk("fill_fifo_count", fifo_count, 8);
    chk("fill_drop_cnt", drop_cnt, 2);
    chk("fill_op_cnt", op_cnt, 11);
    chk("fill_head_stable", rec_data, 8'h01);
    chk("fill_fflags", fflags, 5'b11111);

    // Full with simultaneous push and pop: new record goes to the tail.
    rec_ready = 1'b1;
    exp_q.push_back(8'hAA);
    op(8'hAA);
    chk("fullpp_fifo_count", fifo_count, 8);
    chk("fullpp_drop_cnt", drop_cnt, 2);
    chk("fullpp_op_cnt", op_cnt, 12);
    drain();

    // irq and clr interaction.
    irq_mask = 5'b01000;
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("clr_fflags", fflags, 0);
    chk("clr_irq", irq, 0);
    chk("clr_drop_cnt", drop_cnt, 0);
    exp_q.push_back(8'h08);
    op(8'h08);
    chk("dz_irq", irq, 1);
    chk("dz_fflags", fflags, 5'b01000);
    exp_q.push_back(8'h01);
    clr = 1'b1;
    op(8'h01);
    clr = 1'b0;
    chk("clr_ine_fflags", fflags, 5'b00001);
    chk("clr_ine_irq", irq, 0);
    drain();

`ifdef FPU_STAT_TRAP_EN
    irq_mask = 5'b10000;
    exp_q.push_back(8'h80);
    op(8'h80);
    chk("trap_first", trap, 1);
    exp_q.push_back(8'h80);
    op(8'h80);
    chk("trap_second", trap, 1);
    exp_q.push_back(8'h01);
    op(8'h01);
    chk("trap_ine", trap, 0);
    drain();
`endif

    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
